// File: rtl/vocos_pkg.sv
`default_nettype none
// ============================================================================
// vocos_pkg : shared types and defaults for the vocoder filter path
// Rev 1.0
// ============================================================================
package vocos_pkg;

    localparam int DEFAULT_NUM_BANDS = 8;
    localparam int DEFAULT_SAMPLE_W  = 24;

    typedef logic signed [DEFAULT_SAMPLE_W-1:0]        sample_t;
    typedef logic [$clog2(DEFAULT_NUM_BANDS)-1:0]      band_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } bq_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/biquad_history.sv
`default_nettype none
// ============================================================================
// biquad_history : per-band y[n-1]/y[n-2] register file, shift-on-write
// Rev 1.0
// ============================================================================
module biquad_history
    import vocos_pkg::*;
#(
    parameter int NUM_BANDS = DEFAULT_NUM_BANDS,
    parameter int SAMPLE_W  = DEFAULT_SAMPLE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_wr_en,
    input  logic [$clog2(NUM_BANDS)-1:0] i_wr_band,
    input  logic [SAMPLE_W-1:0]          i_wr_y,
    input  logic [$clog2(NUM_BANDS)-1:0] i_rd_band,
    output logic [SAMPLE_W-1:0]          o_rd_y1,
    output logic [SAMPLE_W-1:0]          o_rd_y2
);

    logic [SAMPLE_W-1:0] r_y1 [NUM_BANDS];
    logic [SAMPLE_W-1:0] r_y2 [NUM_BANDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_y2[i_wr_band] <= r_y1[i_wr_band];
            r_y1[i_wr_band] <= i_wr_y;
        end
    end

    assign o_rd_y1 = r_y1[i_rd_band];
    assign o_rd_y2 = r_y2[i_rd_band];

endmodule
`default_nettype wire

// File: rtl/biquad_sequencer.sv
`default_nettype none
// ============================================================================
// biquad_sequencer : issues one biquad operation per band per input sample
// Rev 1.0
// ============================================================================
module biquad_sequencer
    import vocos_pkg::*;
#(
    parameter int NUM_BANDS = DEFAULT_NUM_BANDS,
    parameter int SAMPLE_W  = DEFAULT_SAMPLE_W
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    output logic                         bq_valid_out,
    output logic [$clog2(NUM_BANDS)-1:0] bq_band_out,
    output logic [SAMPLE_W-1:0]          bq_x_n_out,
    output logic [SAMPLE_W-1:0]          bq_x_n1_out,
    output logic [SAMPLE_W-1:0]          bq_x_n2_out,
    output logic [SAMPLE_W-1:0]          bq_y_n1_out,
    output logic [SAMPLE_W-1:0]          bq_y_n2_out,
    input  logic                         bq_valid_in,
    input  logic [SAMPLE_W-1:0]          bq_y_in,
    output logic                         band_valid_out,
    output logic [$clog2(NUM_BANDS)-1:0] band_idx_out,
    output logic [SAMPLE_W-1:0]          band_y_out,
    output logic                         frame_done_out
);

    localparam int BW = $clog2(NUM_BANDS);
    localparam logic [BW-1:0] C_LAST_BAND = BW'(NUM_BANDS - 1);

    bq_seq_state_t       r_state;
    bq_seq_state_t       w_state_next;
    logic [BW-1:0]       r_band;
    logic [SAMPLE_W-1:0] r_x_n;
    logic [SAMPLE_W-1:0] r_x_n1;
    logic [SAMPLE_W-1:0] r_x_n2;
    logic                r_band_valid;
    logic [BW-1:0]       r_band_idx;
    logic [SAMPLE_W-1:0] r_band_y;
    logic                w_accept;
    logic                w_result;
    logic                w_last;

    // Flush overrides both the sample handshake and a returning result.
    assign w_accept = (r_state == IDLE) && sample_valid_in && !flush_in;
    assign w_result = (r_state == WAIT) && bq_valid_in && !flush_in;
    assign w_last   = (r_band == C_LAST_BAND);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_in) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (sample_valid_in) w_state_next = ISSUE;
                ISSUE:   w_state_next = WAIT;
                WAIT:    if (bq_valid_in) w_state_next = w_last ? DONE : ISSUE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sample_ready_out = (r_state == IDLE);
        bq_valid_out     = (r_state == ISSUE);
        frame_done_out   = (r_state == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_band       <= '0;
            r_x_n        <= '0;
            r_x_n1       <= '0;
            r_x_n2       <= '0;
            r_band_valid <= 1'b0;
            r_band_idx   <= '0;
            r_band_y     <= '0;
        end else if (flush_in) begin
            r_band       <= '0;
            r_x_n        <= '0;
            r_x_n1       <= '0;
            r_x_n2       <= '0;
            r_band_valid <= 1'b0;
            r_band_idx   <= '0;
            r_band_y     <= '0;
        end else begin
            r_band_valid <= w_result;
            if (w_accept) begin
                r_x_n  <= sample_in;
                r_band <= '0;
            end
            if (w_result) begin
                r_band_idx <= r_band;
                r_band_y   <= bq_y_in;
                if (!w_last) r_band <= r_band + 1'b1;
            end
            // x history is common to every band, so it advances once per frame.
            if (r_state == DONE) begin
                r_x_n2 <= r_x_n1;
                r_x_n1 <= r_x_n;
            end
        end
    end

    biquad_history #(
        .NUM_BANDS (NUM_BANDS),
        .SAMPLE_W  (SAMPLE_W)
    ) u_history (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .i_clear   (flush_in),
        .i_wr_en   (w_result),
        .i_wr_band (r_band),
        .i_wr_y    (bq_y_in),
        .i_rd_band (r_band),
        .o_rd_y1   (bq_y_n1_out),
        .o_rd_y2   (bq_y_n2_out)
    );

    assign bq_band_out    = r_band;
    assign bq_x_n_out     = r_x_n;
    assign bq_x_n1_out    = r_x_n1;
    assign bq_x_n2_out    = r_x_n2;
    assign band_valid_out = r_band_valid;
    assign band_idx_out   = r_band_idx;
    assign band_y_out     = r_band_y;

endmodule
`default_nettype wire
